// File: rtl/frame_assembler_pkg.sv
// Shared definitions for the serial-to-word frame assembler: FSM encoding and default geometry.
package frame_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FRAME   = 2'd2
    } fa_state_t;

    localparam int DEF_WORD_W      = 8;
    localparam int DEF_FRAME_WORDS = 32;

endpackage

// File: rtl/word_queue.sv
// Two-entry output queue; push is visible on vld the cycle after it is taken.
// Backpressure: holds head while pop is low; a push into a full queue without a pop is ignored.
module word_queue #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         vld,
    output logic         full
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [1:0]   cnt;
    logic         pop_ok;

    assign pop_ok = pop & (cnt != 2'd0);
    assign head   = e0;
    assign vld    = (cnt != 2'd0);
    assign full   = (cnt == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0 <= push_dat;
                    end else if (cnt == 2'd1) begin
                        e1 <= push_dat;
                    end
                    if (cnt != 2'd2) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push keeps occupancy; full case shifts then refills the tail.
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= push_dat;
                    end else begin
                        e0 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// Shifts serial bits MSB-first into words tagged with frame position and bank; word appears one cycle after its last bit.
// Backpressure: 2-entry queue; a completed word arriving at a full, non-draining queue is dropped and sets sticky oovf.
module frame_assembler
    import frame_assembler_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibit,
    input  logic              ival,
    input  logic              iswch,
    input  logic              iflush,
    output logic [WORD_W-1:0] odat,
    output logic              ovalid,
    input  logic              ordy,
    output logic              ofirst,
    output logic              olast,
    output logic              obank,
    output logic              oovf
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int WC_W = $clog2(FRAME_WORDS);
    localparam int QW   = WORD_W + 3;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(FRAME_WORDS - 1);

    fa_state_t         state;
    fa_state_t         state_nxt;
    logic [BC_W-1:0]   bcnt;
    logic [WC_W-1:0]   wcnt;
    logic [WORD_W-2:0] sreg;
    logic [WORD_W-1:0] shifted;
    logic              bank;
    logic              accept;
    logic              done;
    logic              pop;
    logic              drop;
    logic [QW-1:0]     push_dat;
    logic [QW-1:0]     q_head;
    logic              q_vld;
    logic              q_full;

    assign accept   = ival & ~iswch & ~iflush;
    assign done     = accept & (bcnt == BC_MAX);
    assign shifted  = {sreg, ibit};
    assign push_dat = {shifted, (wcnt == '0), (wcnt == WC_MAX), bank};
    assign ovalid   = q_vld & ~iflush;
    assign pop      = ovalid & ordy;
    assign drop     = done & q_full & ~pop;
    assign {odat, ofirst, olast, obank} = q_head;

    word_queue #(.W(QW)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clr      (iflush),
        .push     (done),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (q_head),
        .vld      (q_vld),
        .full     (q_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (iflush || iswch) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = COLLECT;
                COLLECT: if (done)   state_nxt = FRAME;
                FRAME:   if (accept) state_nxt = COLLECT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt <= '0;
            wcnt <= '0;
            sreg <= '0;
            bank <= 1'b0;
            oovf <= 1'b0;
        end else if (iflush) begin
            bcnt <= '0;
            wcnt <= '0;
            sreg <= '0;
            bank <= 1'b0;
            oovf <= 1'b0;
        end else begin
            if (drop) begin
                oovf <= 1'b1;
            end
            if (iswch) begin
                bank <= ~bank;
                bcnt <= '0;
                wcnt <= '0;
                sreg <= '0;
            end else if (accept) begin
                sreg <= shifted[WORD_W-2:0];
                if (done) begin
                    // Dropped words still consume a frame slot so positions stay aligned.
                    bcnt <= '0;
                    wcnt <= (wcnt == WC_MAX) ? '0 : wcnt + WC_W'(1);
                end else begin
                    bcnt <= bcnt + BC_W'(1);
                end
            end
        end
    end

endmodule
